// File: rtl/prim_alert_ping_pkg.sv
// Shared types, constants and the round-robin channel search for the alert ping scheduler.
package prim_alert_ping_pkg;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Wait = 2'd1,
    Ping = 2'd2
  } state_e;

  localparam logic [15:0] LfsrSeedDefault = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LfsrTaps16 = 16'hB400;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_sel_t;

  // First set bit of en at or above start, wrapping modulo n (n <= 32).
  function automatic rr_sel_t rr_search(logic [31:0] en, logic [4:0] start, int unsigned n);
    rr_sel_t     res;
    int unsigned i;
    res = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      i = (32'(start) + k) % n;
      if (k < n && !res.found && en[i]) begin
        res.found = 1'b1;
        res.idx   = 5'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/prim_lfsr.sv
// Galois LFSR with enable; holds its value while disabled.
module prim_lfsr #(
  parameter int unsigned      Width = 16,
  parameter logic [Width-1:0] Taps  = Width'(16'hB400),
  parameter logic [Width-1:0] Seed  = Width'(16'hACE1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = (state_q >> 1) ^ ({Width{state_q[0]}} & Taps);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/prim_alert_ping_sched.sv
// Ping scheduler: pseudo-random wait, round-robin channel pick, ping with response timeout.
module prim_alert_ping_sched
  import prim_alert_ping_pkg::*;
#(
  parameter int unsigned         NumAlerts = 4,
  parameter int unsigned         WaitCntW  = 16,
  parameter int unsigned         TimeoutW  = 8,
  parameter logic [WaitCntW-1:0] LfsrSeed  = WaitCntW'(LfsrSeedDefault)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [NumAlerts-1:0] alert_en_i,
  input  logic [WaitCntW-1:0]  wait_mask_i,
  input  logic [TimeoutW-1:0]  timeout_cyc_i,
  output logic [NumAlerts-1:0] ping_req_o,
  input  logic [NumAlerts-1:0] ping_ok_i,
  output logic [NumAlerts-1:0] ping_fail_o,
  output logic                 busy_o
);

  state_e                state_q, state_d;
  logic [WaitCntW-1:0]   wait_cnt_q, wait_cnt_d, lfsr, wait_load;
  logic [TimeoutW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [4:0]            sel_q, sel_d, rr_ptr_q, rr_ptr_d, sel_inc;
  logic [NumAlerts-1:0]  ping_req_q, ping_req_d, ping_fail_q, ping_fail_d;
  logic                  busy_q, busy_d, fail_d;
  logic [31:0]           en_ext, ok_ext;
  rr_sel_t               rr;

  prim_lfsr #(
    .Width(WaitCntW),
    .Taps (WaitCntW'(LfsrTaps16)),
    .Seed (LfsrSeed)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .state_o(lfsr)
  );

  assign en_ext    = 32'(alert_en_i);
  assign ok_ext    = 32'(ping_ok_i);
  assign wait_load = lfsr & wait_mask_i;
  assign sel_inc   = (sel_q == 5'(NumAlerts - 1)) ? 5'd0 : sel_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    fail_d     = 1'b0;
    rr         = rr_search(en_ext, rr_ptr_q, NumAlerts);
    if (!en_i) begin
      state_d = Idle;
    end else begin
      case (state_q)
        Idle: begin
          wait_cnt_d = wait_load;
          state_d    = Wait;
        end
        Wait: begin
          if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - WaitCntW'(1);
          end else if (rr.found) begin
            sel_d     = rr.idx;
            tmo_cnt_d = '0;
            state_d   = Ping;
          end else begin
            wait_cnt_d = wait_load;
          end
        end
        Ping: begin
          // A response or a withdrawn channel enable both end the ping without failure
          if (ok_ext[sel_q] || !en_ext[sel_q]) begin
            rr_ptr_d   = sel_inc;
            wait_cnt_d = wait_load;
            state_d    = Wait;
          end else if (tmo_cnt_q == timeout_cyc_i) begin
            fail_d     = 1'b1;
            rr_ptr_d   = sel_inc;
            wait_cnt_d = wait_load;
            state_d    = Wait;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TimeoutW'(1);
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe
  always_comb begin
    ping_req_d  = '0;
    ping_fail_d = '0;
    for (int unsigned i = 0; i < NumAlerts; i++) begin
      ping_req_d[i]  = (state_d == Ping) && (sel_d == 5'(i));
      ping_fail_d[i] = fail_d && (sel_q == 5'(i));
    end
    busy_d = (state_d != Idle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      wait_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      ping_req_q  <= '0;
      ping_fail_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      ping_req_q  <= ping_req_d;
      ping_fail_q <= ping_fail_d;
      busy_q      <= busy_d;
    end
  end

  assign ping_req_o  = ping_req_q;
  assign ping_fail_o = ping_fail_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_prim_alert_ping_sched.sv
// Self-checking bench: table of ping transactions plus hand-written abort/reset sequences.
module tb_prim_alert_ping_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [3:0]  alert_en_i;
  logic [15:0] wait_mask_i;
  logic [7:0]  timeout_cyc_i;
  logic [3:0]  ping_req_o;
  logic [3:0]  ping_ok_i;
  logic [3:0]  ping_fail_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [3:0] alert_en;
    logic [7:0] timeout;
    int         ok_at;    // Ping cycle (1-based) in which ok is driven, 0 = never
    int         ok_ch;
    int         exp_ch;
    int         exp_len;  // cycles ping_req_o stays high
    logic [3:0] exp_fail;
  } vec_t;

  vec_t vecs[17];

  prim_alert_ping_sched u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .alert_en_i   (alert_en_i),
    .wait_mask_i  (wait_mask_i),
    .timeout_cyc_i(timeout_cyc_i),
    .ping_req_o   (ping_req_o),
    .ping_ok_i    (ping_ok_i),
    .ping_fail_o  (ping_fail_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Protocol invariants sampled mid-cycle
  logic [3:0] fail_prev = '0;
  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      checks++;
      if ($countones(ping_req_o) > 1 || $countones(ping_fail_o) > 1 ||
          (ping_fail_o != 0 && fail_prev != 0)) begin
        errors++;
        $display("FAIL invariant: req=%b fail=%b prev_fail=%b at %0t",
                 ping_req_o, ping_fail_o, fail_prev, $time);
      end
    end
    fail_prev = ping_fail_o;
  end

  task automatic run_vec(input vec_t v);
    int         n;
    int         len;
    int         ch;
    logic [3:0] got_req;
    logic [3:0] exp_req;
    alert_en_i    = v.alert_en;
    timeout_cyc_i = v.timeout;
    exp_q.push_back(v.exp_ch);
    n = 0;
    while (ping_req_o == 0 && n < 50) begin
      step();
      n++;
    end
    check("wait_len", n, 1);
    ch = exp_q.pop_front();
    if (ping_req_o == 0) return;
    got_req = ping_req_o;
    exp_req = 4'b0001 << ch;
    check("ping_ch", int'(got_req), int'(exp_req));
    check("fail_idle", int'(ping_fail_o), 0);
    len = 1;
    while (len < 300) begin
      ping_ok_i = (v.ok_at == len) ? 4'(1 << v.ok_ch) : 4'b0000;
      step();
      ping_ok_i = '0;
      if (ping_req_o != got_req) break;
      len++;
    end
    check("req_len", len, v.exp_len);
    check("req_drop", int'(ping_req_o), 0);
    check("fail_val", int'(ping_fail_o), int'(v.exp_fail));
    check("busy_wait", int'(busy_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{4'b1111, 8'd8, 3, 0, 0, 3, 4'b0000};
    vecs[1]  = '{4'b1111, 8'd8, 3, 1, 1, 3, 4'b0000};
    vecs[2]  = '{4'b1111, 8'd8, 3, 2, 2, 3, 4'b0000};
    vecs[3]  = '{4'b1111, 8'd8, 3, 3, 3, 3, 4'b0000};
    vecs[4]  = '{4'b1111, 8'd8, 3, 0, 0, 3, 4'b0000};
    vecs[5]  = '{4'b0101, 8'd8, 1, 2, 2, 1, 4'b0000};
    vecs[6]  = '{4'b0101, 8'd8, 1, 0, 0, 1, 4'b0000};
    vecs[7]  = '{4'b0101, 8'd8, 1, 2, 2, 1, 4'b0000};
    vecs[8]  = '{4'b0101, 8'd8, 1, 0, 0, 1, 4'b0000};
    vecs[9]  = '{4'b1111, 8'd5, 0, 0, 1, 6, 4'b0010};
    vecs[10] = '{4'b1111, 8'd5, 1, 2, 2, 1, 4'b0000};
    vecs[11] = '{4'b1111, 8'd5, 6, 3, 3, 6, 4'b0000};
    vecs[12] = '{4'b1111, 8'd5, 2, 1, 0, 6, 4'b0001};
    vecs[13] = '{4'b1111, 8'd0, 0, 0, 1, 1, 4'b0010};
    vecs[14] = '{4'b1111, 8'd0, 1, 2, 2, 1, 4'b0000};
    vecs[15] = '{4'b1000, 8'd2, 0, 0, 3, 3, 4'b1000};
    vecs[16] = '{4'b1000, 8'd2, 2, 3, 3, 2, 4'b0000};

    rst_i         = 1'b1;
    en_i          = 1'b0;
    alert_en_i    = '0;
    wait_mask_i   = '0;
    timeout_cyc_i = 8'd8;
    ping_ok_i     = '0;
    step();
    step();
    check("rst_req", int'(ping_req_o), 0);
    check("rst_fail", int'(ping_fail_o), 0);
    check("rst_busy", int'(busy_o), 0);

    rst_i      = 1'b0;
    en_i       = 1'b1;
    alert_en_i = 4'b1111;
    step();
    check("idle_to_wait_busy", int'(busy_o), 1);
    check("idle_to_wait_req", int'(ping_req_o), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // No channel enabled: parked in Wait
    alert_en_i = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("none_req", int'(ping_req_o), 0);
      check("none_busy", int'(busy_o), 1);
    end

    // en_i dropped mid-Ping keeps the round-robin pointer
    alert_en_i    = 4'b1111;
    timeout_cyc_i = 8'd8;
    step();
    check("resume_ch0", int'(ping_req_o), 4'b0001);
    step();
    en_i = 1'b0;
    step();
    check("en_drop_req", int'(ping_req_o), 0);
    check("en_drop_fail", int'(ping_fail_o), 0);
    check("en_drop_busy", int'(busy_o), 0);
    en_i = 1'b1;
    step();
    check("reen_busy", int'(busy_o), 1);
    step();
    check("reen_ch0", int'(ping_req_o), 4'b0001);

    // Selected channel disabled mid-Ping: abort, pointer advances
    alert_en_i = 4'b1110;
    step();
    check("abort_req", int'(ping_req_o), 0);
    check("abort_fail", int'(ping_fail_o), 0);
    alert_en_i = 4'b1111;
    step();
    check("abort_next_ch1", int'(ping_req_o), 4'b0010);

    // Reset mid-Wait with en_i high: LFSR back to seed, pointer back to 0
    wait_mask_i = 16'h00F0;
    ping_ok_i   = 4'b0010;
    step();
    ping_ok_i = '0;
    check("ok_wait_req", int'(ping_req_o), 0);
    check("ok_wait_busy", int'(busy_o), 1);
    rst_i = 1'b1;
    step();
    check("midrst_req", int'(ping_req_o), 0);
    check("midrst_fail", int'(ping_fail_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    rst_i = 1'b0;
    step();
    check("postrst_busy", int'(busy_o), 1);
    n = 0;
    while (ping_req_o == 0 && n < 400) begin
      step();
      n++;
    end
    // Seed 16'hACE1 masked by 16'h00F0 gives 224, so 225 Wait cycles
    check("seed_wait_len", n, 225);
    check("postrst_ch0", int'(ping_req_o), 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
